alu_exec_unit: RTL

- Parametrised successor to the combinational ALU-op decoder: decodes the raw instruction to an internal ALU op, executes it and returns a registered result over a valid/ready handshake.
- Adds RV32M divide/remainder (iterative, multi-cycle), optional multiply, illegal-op reporting and XLEN generalisation.
- Sits in the execute stage; operand muxing (rs/PC/imm) happens upstream.

---
 rtl/alu_exec_unit_pkg.sv | 47 ++++
 rtl/alu_divider.sv | 121 ++++++++++++
 rtl/alu_exec_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute unit: internal op encoding, divider FSM
// states, funct7 classes and the major opcodes the decoder recognises.
package alu_exec_unit_pkg;

    typedef enum logic [4:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd,
        AluDiv,
        AluDivu,
        AluRem,
        AluRemu,
        AluPassB,
        AluMul,
        AluMulh,
        AluMulhsu,
        AluMulhu
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDivFix
    } div_state_e;

    localparam logic [6:0] Funct7Base   = 7'b0000000;
    localparam logic [6:0] Funct7Alt    = 7'b0100000;
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             accept operands (only honoured when idle)
//   signed_mode       treat dividend/divisor as two's complement
//   dividend, divisor operands, sampled on start
//   stall             output slot occupied; hold at the final count
//   done              one-cycle strobe in the sign-fix state
//   quotient          signed-corrected quotient, valid while done
//   remainder         signed-corrected remainder, valid while done
//   busy              a divide is in progress
// Division by zero and signed overflow are resolved by the caller, never here.
module alu_divider
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            stall,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] quo_q, quo_d;  // dividend shifts out as quotient shifts in
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            dividend_neg, divisor_neg;
    logic [XLEN:0]   rem_shift, trial;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done      = 1'b0;

        dividend_neg = signed_mode && dividend[XLEN-1];
        divisor_neg  = signed_mode && divisor[XLEN-1];
        rem_shift    = {rem_q, quo_q[XLEN-1]};
        trial        = rem_shift - {1'b0, dvs_q};

        case (state_q)
            StIdle: begin
                if (start) begin
                    quo_d     = dividend_neg ? -dividend : dividend;
                    dvs_d     = divisor_neg ? -divisor : divisor;
                    rem_d     = '0;
                    count_d   = '0;
                    neg_quo_d = dividend_neg ^ divisor_neg;
                    neg_rem_d = dividend_neg;
                    state_d   = StDivRun;
                end
            end
            StDivRun: begin
                // The last step is withheld while the output slot is busy so that
                // the finished quotient is never applied twice.
                if (!((count_q == LastCnt) && stall)) begin
                    if (trial[XLEN]) begin
                        rem_d = rem_shift[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end else begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == LastCnt) begin
                        state_d = StDivFix;
                    end
                end
            end
            StDivFix: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes the raw instruction, runs the operation and returns a
// registered result over a valid/ready handshake. Divides are iterative.
// Build option: define ALU_MUL_EN to enable the two-stage MUL/MULH/MULHSU/MULHU path;
// otherwise those encodings report illegal.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake
//   instruction, op_a, op_b  raw instruction and pre-muxed operands
//   out_valid / out_ready    result handshake
//   result, illegal          registered result and unsupported-op flag
//   busy                     divide in progress
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] ILLEGAL_RESULT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned     ShW    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       imm_shift_base, imm_shift_alt;
    alu_op_e    dec_op;
    logic       dec_illegal;
    logic       unused_instr;

    assign opcode       = instruction[6:0];
    assign funct3       = instruction[14:12];
    assign funct7       = instruction[31:25];
    assign unused_instr = ^{instruction[24:15], instruction[11:7]};

    // Immediate shifts carry one more shamt bit at XLEN=64, so the check narrows.
    if (XLEN == 64) begin : g_imm_sh64
        assign imm_shift_base = (instruction[31:26] == 6'b000000);
        assign imm_shift_alt  = (instruction[31:26] == 6'b010000);
    end else begin : g_imm_sh32
        assign imm_shift_base = (funct7 == Funct7Base);
        assign imm_shift_alt  = (funct7 == Funct7Alt);
    end

    always_comb begin
        dec_op      = AluAdd;
        dec_illegal = 1'b0;
        case (opcode)
            OpcOp: begin
                if (funct7 == Funct7Base) begin
                    case (funct3)
                        3'd0:    dec_op = AluAdd;
                        3'd1:    dec_op = AluSll;
                        3'd2:    dec_op = AluSlt;
                        3'd3:    dec_op = AluSltu;
                        3'd4:    dec_op = AluXor;
                        3'd5:    dec_op = AluSrl;
                        3'd6:    dec_op = AluOr;
                        default: dec_op = AluAnd;
                    endcase
                end else if (funct7 == Funct7Alt) begin
                    if (funct3 == 3'd0) begin
                        dec_op = AluSub;
                    end else if (funct3 == 3'd5) begin
                        dec_op = AluSra;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct7 == Funct7MulDiv) begin
                    case (funct3)
                        3'd4:    dec_op = AluDiv;
                        3'd5:    dec_op = AluDivu;
                        3'd6:    dec_op = AluRem;
                        3'd7:    dec_op = AluRemu;
`ifdef ALU_MUL_EN
                        3'd0:    dec_op = AluMul;
                        3'd1:    dec_op = AluMulh;
                        3'd2:    dec_op = AluMulhsu;
                        default: dec_op = AluMulhu;
`else
                        default: dec_illegal = 1'b1;
`endif
                    endcase
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                case (funct3)
                    3'd0: dec_op = AluAdd;
                    3'd1: begin
                        if (imm_shift_base) dec_op = AluSll;
                        else                dec_illegal = 1'b1;
                    end
                    3'd2: dec_op = AluSlt;
                    3'd3: dec_op = AluSltu;
                    3'd4: dec_op = AluXor;
                    3'd5: begin
                        if (imm_shift_base)     dec_op = AluSrl;
                        else if (imm_shift_alt) dec_op = AluSra;
                        else                    dec_illegal = 1'b1;
                    end
                    3'd6:    dec_op = AluOr;
                    default: dec_op = AluAnd;
                endcase
            end
            OpcLoad, OpcStore, OpcJal, OpcJalr, OpcAuipc: dec_op = AluAdd;
            OpcBranch: dec_op = AluSub;
            OpcLui:    dec_op = AluPassB;
            default:   dec_illegal = 1'b1;
        endcase
    end

    logic [ShW-1:0]  shamt;
    logic            is_div, div_signed, div_by_zero, div_ovf, div_fast;
    logic [XLEN-1:0] alu_res;

    assign shamt       = op_b[ShW-1:0];
    assign is_div      = !dec_illegal && (dec_op inside {AluDiv, AluDivu, AluRem, AluRemu});
    assign div_signed  = (dec_op == AluDiv) || (dec_op == AluRem);
    assign div_by_zero = (op_b == '0);
    assign div_ovf     = div_signed && (op_a == MinNeg) && (&op_b);
    assign div_fast    = div_by_zero || div_ovf;

    always_comb begin
        alu_res = '0;
        case (dec_op)
            AluAdd:   alu_res = op_a + op_b;
            AluSub:   alu_res = op_a - op_b;
            AluSll:   alu_res = op_a << shamt;
            AluSlt:   alu_res = {{(XLEN - 1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            AluSltu:  alu_res = {{(XLEN - 1){1'b0}}, (op_a < op_b)};
            AluXor:   alu_res = op_a ^ op_b;
            AluSrl:   alu_res = op_a >> shamt;
            AluSra:   alu_res = $signed(op_a) >>> shamt;
            AluOr:    alu_res = op_a | op_b;
            AluAnd:   alu_res = op_a & op_b;
            AluPassB: alu_res = op_b;
            // Only the zero-divisor and signed-overflow corners finish here.
            AluDiv, AluDivu: alu_res = div_by_zero ? '1 : op_a;
            AluRem, AluRemu: alu_res = div_by_zero ? op_a : '0;
            default:  alu_res = '0;
        endcase
    end

    logic            accept, single_done, out_stall;
    logic            div_start, div_done, div_busy, div_rem_q;
    logic [XLEN-1:0] div_quotient, div_remainder;
    logic            mul_start, mul_done;
    logic [XLEN-1:0] mul_result;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    assign accept      = in_valid && in_ready;
    assign div_start   = accept && is_div && !div_fast;
    assign single_done = accept && !div_start && !mul_start;
    assign out_stall   = out_valid_q && !out_ready;

    alu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_mode(div_signed),
        .dividend   (op_a),
        .divisor    (op_b),
        .stall      (out_stall),
        .done       (div_done),
        .quotient   (div_quotient),
        .remainder  (div_remainder),
        .busy       (div_busy)
    );

`ifdef ALU_MUL_EN
    logic                is_mul, mul_a_sx, mul_b_sx;
    logic                mul_s1_q, mul_hi_q;
    logic [2*XLEN-1:0]   prod_q, mul_a_ext, mul_b_ext;

    assign is_mul    = !dec_illegal && (dec_op inside {AluMul, AluMulh, AluMulhsu, AluMulhu});
    assign mul_a_sx  = ((dec_op == AluMulh) || (dec_op == AluMulhsu)) && op_a[XLEN-1];
    assign mul_b_sx  = (dec_op == AluMulh) && op_b[XLEN-1];
    assign mul_a_ext = {{XLEN{mul_a_sx}}, op_a};
    assign mul_b_ext = {{XLEN{mul_b_sx}}, op_b};
    assign mul_start = accept && is_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_s1_q <= 1'b0;
            mul_hi_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            mul_s1_q <= mul_start;
            if (mul_start) begin
                prod_q   <= mul_a_ext * mul_b_ext;
                mul_hi_q <= (dec_op != AluMul);
            end
        end
    end

    assign mul_done   = mul_s1_q;
    assign mul_result = mul_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
`else
    assign mul_start  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // mul_done doubles as "stage 1 occupied": no accept that cycle.
    assign in_ready = !div_busy && !mul_done && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (single_done) begin
            out_valid_d = 1'b1;
            result_d    = dec_illegal ? ILLEGAL_RESULT : alu_res;
            illegal_d   = dec_illegal;
        end else if (div_done) begin
            out_valid_d = 1'b1;
            result_d    = div_rem_q ? div_remainder : div_quotient;
            illegal_d   = 1'b0;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = mul_result;
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            div_rem_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            if (div_start) begin
                div_rem_q <= (dec_op == AluRem) || (dec_op == AluRemu);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign busy      = div_busy;

endmodule
